// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding mux, bubble insertion and a stall watchdog.
// Optional bubble performance counter is built when ID_EX_PERF_EN is defined.
module id_ex_stage #(
    parameter int DATA_W    = 16,
    parameter int STALL_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [2:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [3:0]        id_alu_op,
    input  logic              id_use_imm,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              stall_in,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              flush,
    output logic              id_ready,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [2:0]        ex_rd,
    output logic [3:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              stall_timeout,
    output logic [15:0]       bubble_cnt
);

    typedef enum logic [1:0] {
        WD_RUN     = 2'd0,
        WD_STALLED = 2'd1,
        WD_HANG    = 2'd2
    } wd_state_t;

    localparam logic [7:0] STALL_MAX_C = 8'(STALL_MAX);

    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_op_b;
    logic              w_bubble;
    logic              w_stall_q;

    logic              r_valid;
    logic              r_reg_write;
    logic              r_mem_read;
    logic [2:0]        r_rd;
    logic [3:0]        r_alu_op;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_store_data;

    wd_state_t         r_wd_state;
    logic [7:0]        r_stall_cnt;
    logic              r_timeout;

    assign w_bubble  = stall_in | ~id_valid;
    assign w_stall_q = stall_in & id_valid;
    assign id_ready  = ~stall_in;

    // Operand A forwarding select; the reserved code falls back to the register file.
    always_comb begin
        w_fwd_a = rf_rdata1;
        case (forward_a)
            2'b10:   w_fwd_a = ex_fwd_data;
            2'b01:   w_fwd_a = mem_fwd_data;
            default: w_fwd_a = rf_rdata1;
        endcase
    end

    // Operand B forwarding select and immediate substitution.
    always_comb begin
        w_fwd_b = rf_rdata2;
        case (forward_b)
            2'b10:   w_fwd_b = ex_fwd_data;
            2'b01:   w_fwd_b = mem_fwd_data;
            default: w_fwd_b = rf_rdata2;
        endcase
        if (id_use_imm) begin
            w_op_b = id_imm;
        end else begin
            w_op_b = w_fwd_b;
        end
    end

    // Stage register: flush and bubble kill the controls, data fields simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_rd         <= 3'd0;
            r_alu_op     <= 4'd0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_store_data <= '0;
        end else if (flush || w_bubble) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
        end else begin
            r_valid      <= 1'b1;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_rd         <= id_rd;
            r_alu_op     <= id_alu_op;
            r_op_a       <= w_fwd_a;
            r_op_b       <= w_op_b;
            r_store_data <= w_fwd_b;
        end
    end

    // Watchdog FSM; the timeout flag is registered alongside the state it reflects.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wd_state  <= WD_RUN;
            r_stall_cnt <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_wd_state)
                WD_RUN: begin
                    if (w_stall_q) begin
                        if (STALL_MAX_C == 8'd1) begin
                            r_wd_state  <= WD_HANG;
                            r_stall_cnt <= STALL_MAX_C;
                            r_timeout   <= 1'b1;
                        end else begin
                            r_wd_state  <= WD_STALLED;
                            r_stall_cnt <= 8'd1;
                            r_timeout   <= 1'b0;
                        end
                    end else begin
                        r_wd_state  <= WD_RUN;
                        r_stall_cnt <= 8'd0;
                        r_timeout   <= 1'b0;
                    end
                end
                WD_STALLED: begin
                    if (!w_stall_q) begin
                        r_wd_state  <= WD_RUN;
                        r_stall_cnt <= 8'd0;
                        r_timeout   <= 1'b0;
                    end else if (r_stall_cnt + 8'd1 == STALL_MAX_C) begin
                        r_wd_state  <= WD_HANG;
                        r_stall_cnt <= STALL_MAX_C;
                        r_timeout   <= 1'b1;
                    end else begin
                        r_wd_state  <= WD_STALLED;
                        r_stall_cnt <= r_stall_cnt + 8'd1;
                        r_timeout   <= 1'b0;
                    end
                end
                WD_HANG: begin
                    r_wd_state  <= WD_HANG;
                    r_stall_cnt <= STALL_MAX_C;
                    r_timeout   <= 1'b1;
                end
                default: begin
                    r_wd_state  <= WD_RUN;
                    r_stall_cnt <= 8'd0;
                    r_timeout   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ID_EX_PERF_EN
    logic [15:0] r_bubble_cnt;

    // Saturating count of real instructions held back by a stall or killed by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= 16'h0000;
        end else if ((flush || stall_in) && id_valid && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'h0001;
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    assign bubble_cnt = 16'h0000;
`endif

    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_rd         = r_rd;
    assign ex_alu_op     = r_alu_op;
    assign ex_op_a       = r_op_a;
    assign ex_op_b       = r_op_b;
    assign ex_store_data = r_store_data;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural model compared every cycle plus literal checks.
module tb_id_ex_stage;

    localparam int DW   = 16;
    localparam int SMAX = 8;

    logic          clk = 1'b0;
    logic          rst, id_valid, id_reg_write, id_mem_read, id_use_imm, stall_in, flush;
    logic [2:0]    id_rd;
    logic [3:0]    id_alu_op;
    logic [DW-1:0] id_imm, rf_rdata1, rf_rdata2, ex_fwd_data, mem_fwd_data;
    logic [1:0]    forward_a, forward_b;
    logic          id_ready, ex_valid, ex_reg_write, ex_mem_read, stall_timeout;
    logic [2:0]    ex_rd;
    logic [3:0]    ex_alu_op;
    logic [DW-1:0] ex_op_a, ex_op_b, ex_store_data;
    logic [15:0]   bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state
    logic          m_valid = 1'b0, m_rw = 1'b0, m_mr = 1'b0, m_hang = 1'b0;
    logic [2:0]    m_rd = 3'd0;
    logic [3:0]    m_op = 4'd0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_sd = '0;
    int            m_run = 0;
    int            m_bc = 0;

    id_ex_stage #(.DATA_W(DW), .STALL_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_alu_op(id_alu_op),
        .id_use_imm(id_use_imm), .id_imm(id_imm), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .stall_in(stall_in), .forward_a(forward_a), .forward_b(forward_b),
        .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .flush(flush),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
        .stall_timeout(stall_timeout), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] sel(input logic [1:0] s, input logic [DW-1:0] rf);
        if (s == 2'b10) return ex_fwd_data;
        if (s == 2'b01) return mem_fwd_data;
        return rf;
    endfunction

    // Behavioural model: what the EX stage must hold after each edge.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_rd = 3'd0; m_op = 4'd0;
            m_a = '0; m_b = '0; m_sd = '0; m_run = 0; m_hang = 1'b0; m_bc = 0;
        end else begin
            if (flush) begin
                m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_run = 0; m_hang = 1'b0;
            end else if (stall_in || !id_valid) begin
                m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0;
            end else begin
                m_valid = 1'b1; m_rw = id_reg_write; m_mr = id_mem_read;
                m_rd = id_rd; m_op = id_alu_op;
                m_a  = sel(forward_a, rf_rdata1);
                m_sd = sel(forward_b, rf_rdata2);
                m_b  = id_use_imm ? id_imm : m_sd;
            end
            if (!flush) begin
                if (stall_in && id_valid) begin
                    m_run++;
                    if (m_run >= SMAX) m_hang = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
`ifdef ID_EX_PERF_EN
            if ((flush || stall_in) && id_valid && m_bc < 65535) m_bc++;
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("id_ready", 32'(id_ready), 32'(!stall_in));
            check("ex_valid", 32'(ex_valid), 32'(m_valid));
            check("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
            check("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
            check("stall_timeout", 32'(stall_timeout), 32'(m_hang));
            check("bubble_cnt", 32'(bubble_cnt), 32'(m_bc));
            if (m_valid) begin
                check("ex_rd", 32'(ex_rd), 32'(m_rd));
                check("ex_alu_op", 32'(ex_alu_op), 32'(m_op));
                check("ex_op_a", 32'(ex_op_a), 32'(m_a));
                check("ex_op_b", 32'(ex_op_b), 32'(m_b));
                check("ex_store_data", 32'(ex_store_data), 32'(m_sd));
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(input logic [2:0] rd, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [1:0] fa, input logic [1:0] fb,
                         input logic imm_en, input logic [DW-1:0] imm);
        id_valid = 1'b1; id_rd = rd; id_alu_op = op; rf_rdata1 = a; rf_rdata2 = b;
        forward_a = fa; forward_b = fb; id_use_imm = imm_en; id_imm = imm;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rd = 3'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_alu_op = 4'd0; id_use_imm = 1'b0; id_imm = 16'h0000; rf_rdata1 = 16'h0000;
        rf_rdata2 = 16'h0000; stall_in = 1'b1; forward_a = 2'b00; forward_b = 2'b00;
        ex_fwd_data = 16'h0000; mem_fwd_data = 16'h0000; flush = 1'b0;
        #1;
        check("rst_id_ready_low", 32'(id_ready), 32'd0);
        tick();
        chk_en = 1'b1;
        stall_in = 1'b0;
        #1;
        check("rst_id_ready_high", 32'(id_ready), 32'd1);
        tick();
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_op_a", 32'(ex_op_a), 32'd0);
        check("rst_timeout", 32'(stall_timeout), 32'd0);
        check("rst_bubble", 32'(bubble_cnt), 32'd0);
        rst = 1'b0;

        // plain capture
        id_reg_write = 1'b1;
        instr(3'd3, 4'h2, 16'h0011, 16'h0022, 2'b00, 2'b00, 1'b0, 16'h0000);
        tick();
        check("cap_op_a", 32'(ex_op_a), 32'h0011);
        check("cap_op_b", 32'(ex_op_b), 32'h0022);
        check("cap_valid", 32'(ex_valid), 32'd1);
        check("cap_rd", 32'(ex_rd), 32'd3);

        // forwarding with immediate
        ex_fwd_data = 16'hAAAA; mem_fwd_data = 16'h5555;
        instr(3'd4, 4'h6, 16'h0011, 16'h0022, 2'b10, 2'b01, 1'b1, 16'h0007);
        tick();
        check("fwd_op_a", 32'(ex_op_a), 32'hAAAA);
        check("fwd_op_b", 32'(ex_op_b), 32'h0007);
        check("fwd_store", 32'(ex_store_data), 32'h5555);

        // reserved select code reads the register file
        instr(3'd1, 4'h1, 16'h1234, 16'h5678, 2'b11, 2'b11, 1'b0, 16'h0000);
        tick();
        check("rsv_op_a", 32'(ex_op_a), 32'h1234);
        check("rsv_op_b", 32'(ex_op_b), 32'h5678);
        instr(3'd2, 4'h3, 16'h0101, 16'h0202, 2'b01, 2'b10, 1'b0, 16'h0000);
        id_mem_read = 1'b1;
        tick();
        check("mix_op_a", 32'(ex_op_a), 32'h5555);
        check("mix_op_b", 32'(ex_op_b), 32'hAAAA);
        id_mem_read = 1'b0;

        // single stall holds the instruction
        instr(3'd5, 4'h9, 16'h0101, 16'h0202, 2'b00, 2'b00, 1'b0, 16'h0000);
        stall_in = 1'b1;
        #1;
        check("stall_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("stall_valid", 32'(ex_valid), 32'd0);
        check("stall_rw", 32'(ex_reg_write), 32'd0);
        stall_in = 1'b0;
        tick();
        check("held_valid", 32'(ex_valid), 32'd1);
        check("held_rd", 32'(ex_rd), 32'd5);
        check("held_op_a", 32'(ex_op_a), 32'h0101);

        // watchdog fires after the 8th stall edge, is sticky, clears on flush
        stall_in = 1'b1;
        tick(7);
        check("wd_7th", 32'(stall_timeout), 32'd0);
        tick();
        check("wd_8th", 32'(stall_timeout), 32'd1);
        stall_in = 1'b0;
        tick(2);
        check("wd_sticky", 32'(stall_timeout), 32'd1);
        flush = 1'b1;
        tick();
        check("wd_flush", 32'(stall_timeout), 32'd0);
        check("flush_valid", 32'(ex_valid), 32'd0);
        flush = 1'b0;

        // reset in the middle of a stall run
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall_in = 1'b1;
        tick(3);
`ifdef ID_EX_PERF_EN
        check("perf_3", 32'(bubble_cnt), 32'd3);
`endif
        rst = 1'b1;
        tick();
        check("rst2_valid", 32'(ex_valid), 32'd0);
        check("rst2_rd", 32'(ex_rd), 32'd0);
        check("rst2_op_b", 32'(ex_op_b), 32'd0);
        check("rst2_store", 32'(ex_store_data), 32'd0);
        check("rst2_bubble", 32'(bubble_cnt), 32'd0);
        rst = 1'b0;

        // flush + stall at count 5, then a fresh count
        tick(5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fs_valid", 32'(ex_valid), 32'd0);
        check("fs_id_ready", 32'(id_ready), 32'd0);
`ifdef ID_EX_PERF_EN
        check("perf_flush", 32'(bubble_cnt), 32'd6);
`endif
        tick(7);
        check("fs_fresh7", 32'(stall_timeout), 32'd0);
        tick();
        check("fs_fresh8", 32'(stall_timeout), 32'd1);
        stall_in = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // stall without a valid instruction breaks the run
        stall_in = 1'b1;
        tick(5);
        id_valid = 1'b0;
        tick();
        id_valid = 1'b1;
        tick(7);
        check("nv_run7", 32'(stall_timeout), 32'd0);
        tick();
        check("nv_run8", 32'(stall_timeout), 32'd1);
        stall_in = 1'b0;
        id_valid = 1'b0;
        tick();
        check("idle_valid", 32'(ex_valid), 32'd0);
        check("idle_timeout", 32'(stall_timeout), 32'd1);

        // directed captures after recovery
        flush = 1'b1;
        tick();
        flush = 1'b0;
        instr(3'd7, 4'hF, 16'hFFFF, 16'h8000, 2'b00, 2'b10, 1'b0, 16'h0000);
        ex_fwd_data = 16'hBEEF;
        tick();
        check("last_store", 32'(ex_store_data), 32'hBEEF);
        check("last_op_a", 32'(ex_op_a), 32'hFFFF);
        instr(3'd6, 4'hC, 16'h0F0F, 16'hF0F0, 2'b01, 2'b00, 1'b1, 16'hFFF8);
        mem_fwd_data = 16'h1357;
        tick();
        check("last2_op_a", 32'(ex_op_a), 32'h1357);
        check("last2_op_b", 32'(ex_op_b), 32'hFFF8);
        check("last2_store", 32'(ex_store_data), 32'hF0F0);
        tick(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
